// File: rtl/param_mod_counter.sv
// param_mod_counter: modulo-MODULUS up/down counter with synchronous clear,
// range-checked synchronous load, combinational cascade carry (tc_o) and a
// one-cycle load-error pulse.
// Optional feature: define PARAM_MOD_COUNTER_DIV_EN to add div_o, a registered
// clock-enable that is high while the count is in the lower half of its range.
module param_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
`ifdef PARAM_MOD_COUNTER_DIV_EN
    output logic             div_o,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             load_err_o
);

    // Terminal value is held in WIDTH bits so MODULUS == 2**WIDTH never needs
    // a WIDTH+1 bit compare and the wrap never relies on natural overflow.
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] HalfVal = WIDTH'(MODULUS / 2);

    logic [WIDTH-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic             at_max, at_zero, load_ok;

    assign at_max  = (q_q == MaxVal);
    assign at_zero = (q_q == '0);
    // load_val_i < MODULUS, expressed against MaxVal to stay within WIDTH bits
    assign load_ok = (load_val_i <= MaxVal);

    // Next-state: clear beats load beats count beats hold.
    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            if (load_ok) begin
                q_d = load_val_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (en_i) begin
            if (up_dn_i) begin
                q_d = at_max ? '0 : q_q + WIDTH'(1);
            end else begin
                q_d = at_zero ? MaxVal : q_q - WIDTH'(1);
            end
        end
    end

    // Count and error-pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    // Carry is high exactly when the coming enabled edge wraps the count.
    always_comb begin
        tc_o = en_i & ~clr_i & ~load_i & (up_dn_i ? at_max : at_zero);
    end

    assign q_o        = q_q;
    assign load_err_o = err_q;

`ifdef PARAM_MOD_COUNTER_DIV_EN
    logic div_q, div_d;

    // Derived from the next count so div_o tracks q_o with no lag.
    always_comb begin
        div_d = (q_d < HalfVal);
    end

    // Divided enable register; count resets to 0, which is in the lower half.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= 1'b1;
        end else begin
            div_q <= div_d;
        end
    end

    assign div_o = div_q;
`endif

endmodule

// File: doc/param_mod_counter.md
PARAM_MOD_COUNTER -- requirements
Module: param_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the count width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 10, giving the count modulus (2 <= MODULUS <= 2^WIDTH).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: the reset; asynchronous and active-low.
REQ-005 The block SHALL have port en_i, input, 1 bit: count enable.
REQ-006 The block SHALL have port up_dn_i, input, 1 bit: direction; 1 = up, 0 = down.
REQ-007 The block SHALL have port clr_i, input, 1 bit: synchronous clear to 0.
REQ-008 The block SHALL have port load_i, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port load_val_i, input, WIDTH bits: the value to load.
REQ-010 The block SHALL have port q_o, output, WIDTH bits: the registered count.
REQ-011 The block SHALL have port tc_o, output, 1 bit: combinational terminal-count carry for cascading.
REQ-012 The block SHALL have port load_err_o, output, 1 bit: registered one-cycle pulse flagging an illegal load.

Function
REQ-013 Priority per cycle SHALL be clr_i > load_i > en_i > hold.
REQ-014 clr_i=1 SHALL set q_o to 0 on the next edge, regardless of other inputs.
REQ-015 load_i=1 with load_val_i < MODULUS SHALL set q_o to load_val_i on the next edge.
REQ-016 load_i=1 with load_val_i >= MODULUS SHALL leave q_o unchanged and SHALL set load_err_o to 1 for exactly the following cycle.
REQ-017 load_err_o SHALL be 0 in every cycle not covered by REQ-016.
REQ-018 en_i=1 with up_dn_i=1 SHALL increment q_o, wrapping MODULUS-1 -> 0.
REQ-019 en_i=1 with up_dn_i=0 SHALL decrement q_o, wrapping 0 -> MODULUS-1.
REQ-020 en_i=0 with no clear or load SHALL hold q_o.
REQ-021 tc_o SHALL equal en_i AND NOT clr_i AND NOT load_i AND (up_dn_i ? q_o==MODULUS-1 : q_o==0), so that it is high in exactly the cycle before a wrap edge.
REQ-022 A change of up_dn_i SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-023 q_o SHALL never hold a value >= MODULUS.
REQ-024 Wrap logic SHALL be correct when MODULUS = 2^WIDTH, with no overflow artefacts.

Reset
REQ-025 rst_n_i low SHALL immediately (asynchronously) force q_o=0 and load_err_o=0, and div_o=1 when div_o is present.
REQ-026 While rst_n_i is low, all synchronous inputs SHALL be ignored.
REQ-027 After rst_n_i rises, the first rising edge of clk_i SHALL evaluate inputs normally.
REQ-028 Reset asserted mid-count SHALL abort the count with no residual state.

Configuration
REQ-029 With macro PARAM_MOD_COUNTER_DIV_EN defined, the block SHALL add output div_o (1 bit), a registered divided clock-enable.
REQ-030 div_o SHALL be 1 whenever q_o < MODULUS/2 (integer division), otherwise 0.
REQ-031 div_o SHALL be updated from the next count value, so that it has zero lag relative to q_o.
REQ-032 With PARAM_MOD_COUNTER_DIV_EN undefined, div_o and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-033 Reset, then en_i=1, up_dn_i=1 for 12 cycles -> q_o = 0,1,...,9,0,1,2; tc_o high only while q_o=9.
REQ-034 From q_o=2, set up_dn_i=0 with en_i=1 -> q_o = 1,0,9,8; tc_o high only while q_o=0.
REQ-035 load_i=1, load_val_i=7 -> q_o=7 next cycle, load_err_o=0; then load_val_i=12 -> q_o holds 7, load_err_o pulses for 1 cycle.
REQ-036 clr_i=1 and load_i=1 together at q_o=5 -> q_o=0; tc_o=0 during that cycle.
REQ-037 Drop rst_n_i asynchronously between edges at q_o=6 -> q_o=0 immediately; release -> counting resumes from 0.
REQ-038 With PARAM_MOD_COUNTER_DIV_EN defined, MODULUS=5, continuous up count -> div_o high for q_o in {0,1}, low for {2,3,4}; repeat at WIDTH=3, MODULUS=8 -> clean wrap 7->0.
